// File: rtl/mult_leak_pkg.sv
// Shared definitions for the multiplier timing-leak campaign driver.
//   state_e      : campaign FSM encodings
//   TAPS_DEFAULT : default Galois LFSR feedback mask
package mult_leak_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StStart  = 3'd2,
        StWait   = 3'd3,
        StRecord = 3'd4,
        StDone   = 3'd5
    } state_e;

    localparam logic [31:0] TAPS_DEFAULT = 32'h8020_0003;

endpackage

// File: rtl/leak_lfsr.sv
// Galois LFSR operand source for the leak campaign.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (state resets to 1)
//   i_load, i_seed : load seed (zero seed is replaced by 1 so the LFSR never locks up)
//   i_step         : advance one Galois step
//   o_value        : the value the next step produces, so the caller can capture it
//                    in the same cycle the step is taken
module leak_lfsr
    import mult_leak_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter logic [31:0] TAPS  = TAPS_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_value
);

    localparam logic [WIDTH-1:0] TapsW = WIDTH'(TAPS);
    localparam logic [WIDTH-1:0] One   = WIDTH'(1);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = (r_state >> 1) ^ (r_state[0] ? TapsW : '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= One;
        end else if (i_load) begin
            r_state <= (i_seed == '0) ? One : i_seed;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

    assign o_value = w_next;

endmodule

// File: rtl/mult_leak_stimulus.sv
// Campaign driver for constant-time multiplier timing-leak checking.
// Feeds LFSR operands and a shared start pulse to two multiplier copies, measures each
// copy's completion latency and accumulates leak statistics over TRIALS trials.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_run, i_seed           : campaign start level, LFSR seed
//   o_multiplier*/o_multiplicand* : operands for copy One and copy Two
//   o_multStart             : one-cycle start pulse to both copies
//   i_productDoneOne/Two    : done levels from the copies
//   o_busy, o_campaignDone  : status
//   o_leakCount, o_trialCount, o_firstLeakTrial, o_maxSkew, o_timeoutSeen : statistics
module mult_leak_stimulus
    import mult_leak_pkg::*;
#(
    parameter int unsigned  WIDTH   = 32,
    parameter int unsigned  TRIALS  = 256,
    parameter int unsigned  TIMEOUT = 128,
    parameter logic [31:0]  TAPS    = TAPS_DEFAULT,
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_multiplierOne,
    output logic [WIDTH-1:0] o_multiplicandOne,
    output logic [WIDTH-1:0] o_multiplierTwo,
    output logic [WIDTH-1:0] o_multiplicandTwo,
    output logic             o_multStart,
    input  logic             i_productDoneOne,
    input  logic             i_productDoneTwo,
    output logic             o_busy,
    output logic             o_campaignDone,
    output logic [15:0]      o_leakCount,
    output logic [15:0]      o_trialCount,
    output logic [15:0]      o_firstLeakTrial,
    output logic [CNT_W-1:0] o_maxSkew,
    output logic             o_timeoutSeen
);

    localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
    localparam logic [15:0]      TrialsC  = 16'(TRIALS);

    state_e r_state, w_state_d;

    logic [1:0]       r_load_cnt, w_load_cnt_d;
    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_d;
    logic [CNT_W-1:0] r_lat_one, w_lat_one_d;
    logic [CNT_W-1:0] r_lat_two, w_lat_two_d;
    logic             r_done_one, w_done_one_d;
    logic             r_done_two, w_done_two_d;
    logic             r_mult_start, w_mult_start_d;

    logic [WIDTH-1:0] r_mplier_one, w_mplier_one_d;
    logic [WIDTH-1:0] r_mcand_one, w_mcand_one_d;
    logic [WIDTH-1:0] r_mplier_two, w_mplier_two_d;
    logic [WIDTH-1:0] r_mcand_two, w_mcand_two_d;

    logic [15:0]      r_leak_count, w_leak_count_d;
    logic [15:0]      r_trial_count, w_trial_count_d;
    logic [15:0]      r_first_leak, w_first_leak_d;
    logic [CNT_W-1:0] r_max_skew, w_max_skew_d;
    logic             r_timeout_seen, w_timeout_seen_d;

    logic             w_lfsr_load;
    logic             w_lfsr_step;
    logic [WIDTH-1:0] w_lfsr_value;

    logic [CNT_W-1:0] w_wait_inc;
    logic [CNT_W-1:0] w_skew;
    logic [15:0]      w_trial_inc;
    logic             w_timeout;
    logic             w_leak;

    leak_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_lfsr_load),
        .i_seed  (i_seed),
        .i_step  (w_lfsr_step),
        .o_value (w_lfsr_value)
    );

    always_comb begin
        w_wait_inc  = r_wait_cnt + 1'b1;
        w_trial_inc = r_trial_count + 16'd1;
        w_skew      = (r_lat_one >= r_lat_two) ? (r_lat_one - r_lat_two)
                                               : (r_lat_two - r_lat_one);
        // A trial is a timeout unless both copies finished by the last WAIT update.
        w_timeout   = !(r_done_one && r_done_two);
        w_leak      = (w_skew != '0) || w_timeout;
    end

    always_comb begin
        w_state_d        = r_state;
        w_load_cnt_d     = r_load_cnt;
        w_wait_cnt_d     = r_wait_cnt;
        w_lat_one_d      = r_lat_one;
        w_lat_two_d      = r_lat_two;
        w_done_one_d     = r_done_one;
        w_done_two_d     = r_done_two;
        w_mplier_one_d   = r_mplier_one;
        w_mcand_one_d    = r_mcand_one;
        w_mplier_two_d   = r_mplier_two;
        w_mcand_two_d    = r_mcand_two;
        w_leak_count_d   = r_leak_count;
        w_trial_count_d  = r_trial_count;
        w_first_leak_d   = r_first_leak;
        w_max_skew_d     = r_max_skew;
        w_timeout_seen_d = r_timeout_seen;
        w_lfsr_load      = 1'b0;
        w_lfsr_step      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_run) begin
                    w_lfsr_load      = 1'b1;
                    w_leak_count_d   = '0;
                    w_trial_count_d  = '0;
                    w_first_leak_d   = '0;
                    w_max_skew_d     = '0;
                    w_timeout_seen_d = 1'b0;
                    w_state_d        = StLoad;
                end
            end
            StLoad: begin
                w_lfsr_step  = 1'b1;
                w_load_cnt_d = r_load_cnt + 2'd1;
                unique case (r_load_cnt)
                    2'd0: w_mplier_one_d = w_lfsr_value;
                    2'd1: w_mcand_one_d  = w_lfsr_value;
                    2'd2: w_mplier_two_d = w_lfsr_value;
                    2'd3: w_mcand_two_d  = w_lfsr_value;
                    default: ;
                endcase
                if (r_load_cnt == 2'd3) begin
                    w_state_d = StStart;
                end
            end
            StStart: begin
                w_wait_cnt_d = '0;
                w_lat_one_d  = '0;
                w_lat_two_d  = '0;
                w_done_one_d = 1'b0;
                w_done_two_d = 1'b0;
                w_state_d    = StWait;
            end
            StWait: begin
                w_wait_cnt_d = w_wait_inc;
                if (!r_done_one && i_productDoneOne) begin
                    w_done_one_d = 1'b1;
                    w_lat_one_d  = w_wait_inc;
                end
                if (!r_done_two && i_productDoneTwo) begin
                    w_done_two_d = 1'b1;
                    w_lat_two_d  = w_wait_inc;
                end
                // Both-done wins over timeout when they coincide.
                if (w_done_one_d && w_done_two_d) begin
                    w_state_d = StRecord;
                end else if (w_wait_inc == TimeoutC) begin
                    if (!w_done_one_d) w_lat_one_d = TimeoutC;
                    if (!w_done_two_d) w_lat_two_d = TimeoutC;
                    w_state_d = StRecord;
                end
            end
            StRecord: begin
                w_trial_count_d = w_trial_inc;
                if (w_skew > r_max_skew) begin
                    w_max_skew_d = w_skew;
                end
                if (w_leak) begin
                    if (r_leak_count != 16'hFFFF) begin
                        w_leak_count_d = r_leak_count + 16'd1;
                    end
                    if (r_first_leak == '0) begin
                        w_first_leak_d = w_trial_inc;
                    end
                end
                if (w_timeout) begin
                    w_timeout_seen_d = 1'b1;
                end
                w_state_d = (w_trial_inc == TrialsC) ? StDone : StLoad;
            end
            StDone: begin
                if (!i_run) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Registered so the pulse coincides exactly with the START state.
        w_mult_start_d = (w_state_d == StStart);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_load_cnt     <= '0;
            r_wait_cnt     <= '0;
            r_lat_one      <= '0;
            r_lat_two      <= '0;
            r_done_one     <= 1'b0;
            r_done_two     <= 1'b0;
            r_mult_start   <= 1'b0;
            r_mplier_one   <= '0;
            r_mcand_one    <= '0;
            r_mplier_two   <= '0;
            r_mcand_two    <= '0;
            r_leak_count   <= '0;
            r_trial_count  <= '0;
            r_first_leak   <= '0;
            r_max_skew     <= '0;
            r_timeout_seen <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_load_cnt     <= w_load_cnt_d;
            r_wait_cnt     <= w_wait_cnt_d;
            r_lat_one      <= w_lat_one_d;
            r_lat_two      <= w_lat_two_d;
            r_done_one     <= w_done_one_d;
            r_done_two     <= w_done_two_d;
            r_mult_start   <= w_mult_start_d;
            r_mplier_one   <= w_mplier_one_d;
            r_mcand_one    <= w_mcand_one_d;
            r_mplier_two   <= w_mplier_two_d;
            r_mcand_two    <= w_mcand_two_d;
            r_leak_count   <= w_leak_count_d;
            r_trial_count  <= w_trial_count_d;
            r_first_leak   <= w_first_leak_d;
            r_max_skew     <= w_max_skew_d;
            r_timeout_seen <= w_timeout_seen_d;
        end
    end

    assign o_multiplierOne   = r_mplier_one;
    assign o_multiplicandOne = r_mcand_one;
    assign o_multiplierTwo   = r_mplier_two;
    assign o_multiplicandTwo = r_mcand_two;
    assign o_multStart       = r_mult_start;
    assign o_busy            = (r_state != StIdle) && (r_state != StDone);
    assign o_campaignDone    = (r_state == StDone);
    assign o_leakCount       = r_leak_count;
    assign o_trialCount      = r_trial_count;
    assign o_firstLeakTrial  = r_first_leak;
    assign o_maxSkew         = r_max_skew;
    assign o_timeoutSeen     = r_timeout_seen;

endmodule

// File: tb/tb_mult_leak_stimulus.sv
// Directed bench for mult_leak_stimulus with two behavioural multiplier copies whose
// per-trial latencies come from small tables.
module tb_mult_leak_stimulus;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TRIALS  = 4;
    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

    logic             clk;
    logic             rst_n;
    logic             run;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] mplier_one, mcand_one, mplier_two, mcand_two;
    logic             mult_start;
    logic             done_one, done_two;
    logic             busy, campaign_done;
    logic [15:0]      leak_count, trial_count, first_leak;
    logic [CNT_W-1:0] max_skew;
    logic             timeout_seen;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural copies: latency L means done is seen in WAIT cycle L; 0 means never.
    int          lat_one_tab[16];
    int          lat_two_tab[16];
    bit          pulse_mode;
    int          trial_idx;
    int          k;
    bit          active;
    int          cur_one, cur_two;
    logic [31:0] cap_ops[5];

    mult_leak_stimulus #(
        .WIDTH   (WIDTH),
        .TRIALS  (TRIALS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_run             (run),
        .i_seed            (seed),
        .o_multiplierOne   (mplier_one),
        .o_multiplicandOne (mcand_one),
        .o_multiplierTwo   (mplier_two),
        .o_multiplicandTwo (mcand_two),
        .o_multStart       (mult_start),
        .i_productDoneOne  (done_one),
        .i_productDoneTwo  (done_two),
        .o_busy            (busy),
        .o_campaignDone    (campaign_done),
        .o_leakCount       (leak_count),
        .o_trialCount      (trial_count),
        .o_firstLeakTrial  (first_leak),
        .o_maxSkew         (max_skew),
        .o_timeoutSeen     (timeout_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            k         <= 0;
            trial_idx <= 0;
        end else if (mult_start) begin
            active    <= 1'b1;
            k         <= 1;
            trial_idx <= trial_idx + 1;
            if (trial_idx == 0) begin
                cap_ops[0] <= mplier_one;
                cap_ops[1] <= mcand_one;
                cap_ops[2] <= mplier_two;
                cap_ops[3] <= mcand_two;
            end else if (trial_idx == 1) begin
                cap_ops[4] <= mplier_one;
            end
        end else if (active) begin
            k <= k + 1;
        end
    end

    always_comb begin
        cur_one  = lat_one_tab[trial_idx[3:0]];
        cur_two  = lat_two_tab[trial_idx[3:0]];
        done_one = active && (cur_one != 0) && (pulse_mode ? (k == cur_one) : (k >= cur_one));
        done_two = active && (cur_two != 0) && (pulse_mode ? (k == cur_two) : (k >= cur_two));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_lats(input int l1, input int l2);
        for (int i = 0; i < 16; i++) begin
            lat_one_tab[i] = l1;
            lat_two_tab[i] = l2;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_campaign(input logic [WIDTH-1:0] s);
        @(negedge clk);
        seed = s;
        run  = 1'b1;
    endtask

    // Counts rising edges after the one that leaves IDLE until campaignDone is seen.
    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        @(posedge clk);
        while (cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (campaign_done) break;
        end
        check({tag, "_reached_done"}, 32'(campaign_done), 32'd1);
    endtask

    int cyc;

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        seed       = '0;
        pulse_mode = 1'b0;
        set_lats(0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(mult_start), 32'd0);
        check("rst_done", 32'(campaign_done), 32'd0);
        check("rst_trials", 32'(trial_count), 32'd0);
        check("rst_leaks", 32'(leak_count), 32'd0);
        check("rst_ops", mplier_one | mcand_one | mplier_two | mcand_two, 32'd0);
        rst_n = 1'b1;

        // Equal latency, no leak
        set_lats(33, 33);
        apply_reset();
        start_campaign(32'd1);
        wait_done("equal", 400, cyc);
        check("equal_cycles", 32'(cyc), 32'd156);
        check("equal_leaks", 32'(leak_count), 32'd0);
        check("equal_maxskew", 32'(max_skew), 32'd0);
        check("equal_first", 32'(first_leak), 32'd0);
        check("equal_trials", 32'(trial_count), 32'd4);
        check("equal_busy", 32'(busy), 32'd0);
        check("equal_op1", cap_ops[0], 32'h8020_0003);
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_done_low", 32'(campaign_done), 32'd0);
        check("idle_stats_kept", 32'(trial_count), 32'd4);

        // Single-trial leak on trial 2
        set_lats(33, 33);
        lat_two_tab[2] = 34;
        apply_reset();
        start_campaign(32'd5);
        wait_done("skew", 400, cyc);
        check("skew_leaks", 32'(leak_count), 32'd1);
        check("skew_first", 32'(first_leak), 32'd2);
        check("skew_maxskew", 32'(max_skew), 32'd1);
        check("skew_timeout", 32'(timeout_seen), 32'd0);
        check("skew_trials", 32'(trial_count), 32'd4);

        // Timeout: copy Two never finishes, WAIT lasts TIMEOUT cycles per trial
        set_lats(10, 0);
        apply_reset();
        start_campaign(32'd9);
        wait_done("tmo", 1000, cyc);
        check("tmo_cycles", 32'(cyc), 32'd424);
        check("tmo_leaks", 32'(leak_count), 32'd4);
        check("tmo_seen", 32'(timeout_seen), 32'd1);
        check("tmo_maxskew", 32'(max_skew), 32'd90);
        check("tmo_first", 32'(first_leak), 32'd1);

        // Zero seed, LFSR sequence, single-cycle done pulses, run held through DONE
        set_lats(5, 5);
        pulse_mode = 1'b1;
        apply_reset();
        start_campaign(32'd0);
        wait_done("lfsr", 200, cyc);
        check("lfsr_cycles", 32'(cyc), 32'd44);
        check("lfsr_mplier_one", cap_ops[0], 32'h8020_0003);
        check("lfsr_mcand_one", cap_ops[1], 32'hC030_0002);
        check("lfsr_mplier_two", cap_ops[2], 32'h6018_0001);
        check("lfsr_mcand_two", cap_ops[3], 32'hB02C_0003);
        check("lfsr_trial2_op", cap_ops[4], 32'hD836_0002);
        check("pulse_leaks", 32'(leak_count), 32'd0);
        check("pulse_timeout", 32'(timeout_seen), 32'd0);
        repeat (5) @(negedge clk);
        check("hold_done", 32'(campaign_done), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_trials", 32'(trial_count), 32'd4);
        pulse_mode = 1'b0;

        // Reset in the WAIT of trial 3, then a fresh campaign
        set_lats(20, 20);
        apply_reset();
        start_campaign(32'd7);
        cyc = 0;
        while (!(trial_idx == 3 && k >= 3) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reached_wait3", 32'(trial_idx == 3 && k >= 3), 32'd1);
        check("mid_trials_before", 32'(trial_count), 32'd2);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_start", 32'(mult_start), 32'd0);
        check("mid_trials", 32'(trial_count), 32'd0);
        check("mid_ops", mplier_one | mcand_one | mplier_two | mcand_two, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_campaign(32'd7);
        wait_done("fresh", 400, cyc);
        check("fresh_cycles", 32'(cyc), 32'd104);
        check("fresh_trials", 32'(trial_count), 32'd4);
        check("fresh_leaks", 32'(leak_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_leak_stimulus.md
# mult_leak_stimulus

Campaign driver for constant-time multiplier timing-leak checking. Generates pseudo-random operand pairs for two multiplier copies and issues a shared start pulse. Measures each copy's completion latency and accumulates leak statistics over a fixed number of trials. It sits on the input side of the two-copy tester: its operand and start outputs feed both multiplier instances, and their done signals come back to it.

## Interface
Parameters:
- WIDTH, 32, operand width of each multiplier.
- TRIALS, 256, number of operand pairs per campaign; must be ≥1.
- TIMEOUT, 128, maximum wait cycles per trial; must be ≥1.
- TAPS, 32'h80200003, Galois LFSR feedback mask; low WIDTH bits are used.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; a campaign starts when high in IDLE.
- seed  in  WIDTH  LFSR seed, sampled on leaving IDLE.
- multiplierOne, multiplicandOne, multiplierTwo, multiplicandTwo  out  WIDTH each  operands for copy One and copy Two.
- multStart  out  1  single-cycle start pulse to both copies.
- productDoneOne, productDoneTwo  in  1 each  done levels from the two copies.
- busy  out  1  high in every state except IDLE and DONE.
- campaignDone  out  1  high in DONE.
- leakCount  out  16  trials with skew≠0 or timeout; saturates at 16'hFFFF.
- trialCount  out  16  completed trials.
- firstLeakTrial  out  16  1-based index of the first leaking trial; 0 means no leak yet.
- maxSkew  out  CNT_W  largest |latOne−latTwo| seen, where CNT_W=$clog2(TIMEOUT+1).
- timeoutSeen  out  1  sticky; set if any trial hit TIMEOUT.

## Operation
- States: IDLE, LOAD, START, WAIT, RECORD, DONE.
- Reset: state IDLE; all outputs and counters 0; operand regs 0; LFSR 1.
- IDLE, run=1:
  - Load LFSR with seed; a seed of 0 is replaced by 1.
  - Clear all statistics.
  - Go to LOAD.
- LOAD: exactly 4 cycles. Each cycle the LFSR advances one Galois step (shift right; if the old LSB=1, XOR TAPS). The new value is written to multiplierOne, multiplicandOne, multiplierTwo, multiplicandTwo in that order. Then go to START.
- START: 1 cycle.
  - multStart=1.
  - Clear waitCnt, latOne, latTwo, and the doneOne/doneTwo flags.
  - Go to WAIT.
- WAIT, each cycle:
  - waitCnt increments.
  - For each copy whose flag is clear and whose productDone is high: set the flag and latch lat = waitCnt+1. Done high in the first WAIT cycle therefore gives lat=1.
  - Exit to RECORD when both flags are set after this cycle's update, or when waitCnt+1==TIMEOUT.
  - A copy that never finishes keeps lat=TIMEOUT.
- RECORD: 1 cycle.
  - trialCount+1.
  - skew = |latOne−latTwo|; maxSkew = max(maxSkew, skew).
  - A leak is skew≠0 or a timeout. On a leak, leakCount+1 (saturating), and firstLeakTrial is set to the new trialCount if it was 0.
  - A timeout also sets timeoutSeen.
  - If the new trialCount==TRIALS go to DONE, else go to LOAD.
- DONE: campaignDone=1 and statistics held. When run=0, go to IDLE; statistics stay visible until the next campaign starts.
- run is ignored outside IDLE and DONE.
- Operand outputs are stable from the end of LOAD through RECORD.
- Copy and done inputs: done is treated as a level. Done already high on entry to WAIT counts as lat=1; a single-cycle done pulse is sufficient.

## Timing
- Trial length = 4 (LOAD) + 1 (START) + W (WAIT) + 1 (RECORD), where W = max(latOne, latTwo) capped at TIMEOUT.
- multStart is registered and high for exactly one cycle per trial. It is never asserted in IDLE, DONE or reset.
- Statistics outputs update on the clock edge that leaves RECORD.
- Reset mid-operation: state returns immediately to IDLE with all outputs 0 and multStart deasserted. No partial trial is recorded.
- Timeout and both-done in the same cycle: recorded as done, with no timeout, if both flags are set by that cycle's update.

## Structure
- Shared package mult_leak_pkg holds the state enum (6 encodings) and the default TAPS constant.
- One sub-module, leak_lfsr: WIDTH and TAPS parameters; load, seed and step inputs; value output. Zero-seed substitution is done inside it.
- CNT_W is a localparam derived from TIMEOUT.

## Test plan
- Equal latency, no leak: seed=1, TRIALS=4, both model copies raise done 33 cycles after multStart. Require leakCount=0, maxSkew=0, firstLeakTrial=0, trialCount=4, and campaignDone 156 cycles after run rises.
- Single-trial leak: copy Two is 1 cycle slower on trial 2 only. Require leakCount=1, firstLeakTrial=2, maxSkew=1, timeoutSeen=0.
- Timeout: TIMEOUT=100, copy Two never asserts done. Require each trial's WAIT to last 100 cycles, leakCount=TRIALS, timeoutSeen=1, maxSkew=100−latOne.
- LFSR contents: seed=0 with default TAPS. Require first-trial multiplierOne=32'h80200003 (1 replaced, stepped once), and the following three operands to match the Galois sequence from that value.
- Reset mid-WAIT: drive rst=0 while in WAIT of trial 3. Require busy=0, multStart=0, trialCount=0 and all operands 0 during reset; after release and run=1, a fresh campaign completes normally.
- Done pulse and run hold: a 1-cycle done pulse is accepted, and run held high through DONE keeps campaignDone=1.
